// File: rtl/warp_rr_scheduler_pkg.sv
// Shared fetch/decode definitions for the warp issue scheduler: sizes, state encoding
// and the one-hot rotator/encoder helpers used by the round-robin picker.
package warp_rr_scheduler_pkg;

    localparam int NUM_WARPS = 8;
    localparam int WARP_ID_W = 3;

    // Reset pointer sits on the last warp so the first search starts at warp 0.
    localparam logic [NUM_WARPS-1:0] MR_RESET = 8'b1000_0000;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } sched_state_e;

    function automatic logic [NUM_WARPS-1:0] rot_dn(input logic [NUM_WARPS-1:0] v,
                                                    input logic [WARP_ID_W-1:0] n);
        logic [NUM_WARPS-1:0] r;
        logic [WARP_ID_W-1:0] src;
        r = '0;
        for (int j = 0; j < NUM_WARPS; j++) begin
            src  = WARP_ID_W'(j) + n;
            r[j] = v[src];
        end
        return r;
    endfunction

    function automatic logic [NUM_WARPS-1:0] rot_up(input logic [NUM_WARPS-1:0] v,
                                                    input logic [WARP_ID_W-1:0] n);
        logic [NUM_WARPS-1:0] r;
        logic [WARP_ID_W-1:0] dst;
        r = '0;
        for (int j = 0; j < NUM_WARPS; j++) begin
            dst    = WARP_ID_W'(j) + n;
            r[dst] = v[j];
        end
        return r;
    endfunction

    function automatic logic [WARP_ID_W-1:0] onehot_to_idx(input logic [NUM_WARPS-1:0] v);
        logic [WARP_ID_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            if (v[i]) idx = idx | WARP_ID_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/warp_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: first eligible warp strictly after the pointer,
// wrapping upward, with the pointer's own warp as the last candidate.
module warp_rr_scheduler_rr_pick
    import warp_rr_scheduler_pkg::*;
(
    input  logic [NUM_WARPS-1:0] elig_i,
    input  logic [NUM_WARPS-1:0] ptr_i,
    output logic                 any_o,
    output logic [NUM_WARPS-1:0] sel_o,
    output logic [WARP_ID_W-1:0] sel_id_o
);

    logic [WARP_ID_W-1:0] start_idx;
    logic [NUM_WARPS-1:0] elig_rot;
    logic [NUM_WARPS-1:0] sel_rot;

    assign start_idx = onehot_to_idx(ptr_i) + WARP_ID_W'(1);
    assign elig_rot  = rot_dn(elig_i, start_idx);

    // Isolate the lowest set bit of the rotated vector.
    assign sel_rot   = elig_rot & (~elig_rot + NUM_WARPS'(1));

    assign sel_o     = rot_up(sel_rot, start_idx);
    assign sel_id_o  = onehot_to_idx(sel_o);
    assign any_o     = |elig_i;

endmodule

// File: rtl/warp_rr_scheduler.sv
// Round-robin warp issue scheduler with valid/ready grant hold, optional same-warp
// burst issue and an exported most-recently-accepted pointer.
//
// state | meaning
// IDLE  | no grant presented; waiting for any eligible warp
// GRANT | gnt/gnt_id presented and held until accepted or flushed
module warp_rr_scheduler
    import warp_rr_scheduler_pkg::*;
#(
    parameter int MAX_BURST = 2,
    parameter int BURST_W   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_WARPS-1:0] req,
    input  logic [NUM_WARPS-1:0] mask,
    input  logic                 flush,
    input  logic                 gnt_ready,
    output logic                 gnt_valid,
    output logic [NUM_WARPS-1:0] gnt,
    output logic [WARP_ID_W-1:0] gnt_id,
    output logic [NUM_WARPS-1:0] mr_ptr
);

    if (MAX_BURST < 1 || MAX_BURST > 8 || (1 << BURST_W) < MAX_BURST) begin : g_param_chk
        $error("warp_rr_scheduler: MAX_BURST/BURST_W out of range");
    end

    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

    sched_state_e         state_q, state_d;
    logic [NUM_WARPS-1:0] gnt_q, gnt_d;
    logic [WARP_ID_W-1:0] gnt_id_q, gnt_id_d;
    logic [BURST_W-1:0]   burst_q, burst_d;
    logic [NUM_WARPS-1:0] mr_q, mr_d;

    logic [NUM_WARPS-1:0] elig;
    logic [NUM_WARPS-1:0] pick_ptr;
    logic                 pick_any;
    logic [NUM_WARPS-1:0] pick_sel;
    logic [WARP_ID_W-1:0] pick_id;

    assign elig = req & ~mask;

    // On accept the new pointer equals the current grant, so one picker serves both states.
    assign pick_ptr = (state_q == GRANT) ? gnt_q : mr_q;

    warp_rr_scheduler_rr_pick u_rr_pick (
        .elig_i   (elig),
        .ptr_i    (pick_ptr),
        .any_o    (pick_any),
        .sel_o    (pick_sel),
        .sel_id_o (pick_id)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        burst_d  = burst_q;
        mr_d     = mr_q;

        if (flush) begin
            state_d  = IDLE;
            gnt_d    = '0;
            gnt_id_d = '0;
            burst_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        state_d  = GRANT;
                        gnt_d    = pick_sel;
                        gnt_id_d = pick_id;
                        burst_d  = '0;
                    end
                end
                GRANT: begin
                    if (gnt_ready) begin
                        mr_d = gnt_q;
                        if (elig[gnt_id_q] && (burst_q < BURST_LAST)) begin
                            burst_d = burst_q + BURST_W'(1);
                        end else if (pick_any) begin
                            gnt_d    = pick_sel;
                            gnt_id_d = pick_id;
                            burst_d  = '0;
                        end else begin
                            state_d  = IDLE;
                            gnt_d    = '0;
                            gnt_id_d = '0;
                            burst_d  = '0;
                        end
                    end
                end
                default: begin
                    state_d  = IDLE;
                    gnt_d    = '0;
                    gnt_id_d = '0;
                    burst_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            burst_q  <= '0;
            mr_q     <= MR_RESET;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            burst_q  <= burst_d;
            mr_q     <= mr_d;
        end
    end

    assign gnt_valid = (state_q == GRANT);
    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign mr_ptr    = mr_q;

endmodule

// File: tb/tb_warp_rr_scheduler.sv
// Bench for warp_rr_scheduler: two instances (MAX_BURST=1 and 2) driven together and
// compared every cycle against a behavioural model, plus hand-computed directed checks.
module tb_warp_rr_scheduler;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] mask;
    logic       flush;
    logic       gnt_ready;

    logic [1:0]      d_valid;
    logic [1:0][7:0] d_gnt;
    logic [1:0][2:0] d_id;
    logic [1:0][7:0] d_mr;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    int MB[2] = '{1, 2};
    int m_gnt[2];
    int m_burst[2];
    int m_mr[2];

    warp_rr_scheduler #(.MAX_BURST(1), .BURST_W(3)) dut_b1 (
        .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .flush(flush),
        .gnt_ready(gnt_ready), .gnt_valid(d_valid[0]), .gnt(d_gnt[0]),
        .gnt_id(d_id[0]), .mr_ptr(d_mr[0])
    );

    warp_rr_scheduler #(.MAX_BURST(2), .BURST_W(3)) dut_b2 (
        .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .flush(flush),
        .gnt_ready(gnt_ready), .gnt_valid(d_valid[1]), .gnt(d_gnt[1]),
        .gnt_id(d_id[1]), .mr_ptr(d_mr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] oh(input int i);
        logic [7:0] one;
        one = 8'd1;
        return (i < 0) ? 8'h00 : (one << i);
    endfunction

    // First eligible warp strictly after 'after', wrapping; -1 if none.
    function automatic int search(input logic [7:0] e, input int after);
        for (int i = 1; i <= 8; i++) begin
            if (e[(after + i) % 8]) return (after + i) % 8;
        end
        return -1;
    endfunction

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_gnt[k] = -1;
            m_burst[k] = 0;
            m_mr[k] = 7;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int g, b, m;
            logic [7:0] e;
            g = m_gnt[k];
            b = m_burst[k];
            m = m_mr[k];
            e = req & ~mask;
            if (!rst_n) begin
                g = -1; b = 0; m = 7;
            end else if (flush) begin
                g = -1; b = 0;
            end else if (g < 0) begin
                g = search(e, m);
                b = 0;
            end else if (gnt_ready) begin
                m = g;
                if (e[g] && b < MB[k] - 1) begin
                    b = b + 1;
                end else begin
                    g = search(e, m);
                    b = 0;
                end
            end
            m_gnt[k]   <= g;
            m_burst[k] <= b;
            m_mr[k]    <= m;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("mdl_b%0d_valid", MB[k]), 32'(d_valid[k]), 32'(m_gnt[k] >= 0));
                check($sformatf("mdl_b%0d_gnt", MB[k]), 32'(d_gnt[k]), 32'(oh(m_gnt[k])));
                check($sformatf("mdl_b%0d_id", MB[k]), 32'(d_id[k]),
                      32'((m_gnt[k] < 0) ? 0 : m_gnt[k]));
                check($sformatf("mdl_b%0d_mr", MB[k]), 32'(d_mr[k]), 32'(oh(m_mr[k])));
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0; req = 8'h00; mask = 8'h00; flush = 1'b0; gnt_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; req = 8'h00; mask = 8'h00; flush = 1'b0; gnt_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            check("rst_valid", 32'(d_valid[k]), 32'd0);
            check("rst_gnt", 32'(d_gnt[k]), 32'd0);
            check("rst_id", 32'(d_id[k]), 32'd0);
            check("rst_mr", 32'(d_mr[k]), 32'h80);
        end

        // all warps eligible, always ready
        rst_n = 1'b1; req = 8'hFF; gnt_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check("rr_b1_id", 32'(d_id[0]), 32'(i % 8));
            check("rr_b1_mr", 32'(d_mr[0]), 32'(oh((i + 7) % 8)));
            check("rr_b2_id", 32'(d_id[1]), 32'((i / 2) % 8));
        end

        // grant held while not ready, even after request drops
        do_reset();
        req = 8'h24;
        @(negedge clk);
        check("hold_first", 32'(d_gnt[0]), 32'h04);
        req = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_b1_gnt", 32'(d_gnt[0]), 32'h04);
            check("hold_b2_gnt", 32'(d_gnt[1]), 32'h04);
            check("hold_valid", 32'(d_valid[0]), 32'd1);
        end
        gnt_ready = 1'b1;
        @(negedge clk);
        check("acc_idle_valid", 32'(d_valid[0]), 32'd0);
        check("acc_idle_gnt", 32'(d_gnt[1]), 32'h00);
        check("acc_mr", 32'(d_mr[0]), 32'h04);

        // burst of two between warps 0 and 1
        do_reset();
        req = 8'h03; gnt_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("burst_b2_id", 32'(d_id[1]), 32'((i / 2) % 2));
            check("burst_b1_id", 32'(d_id[0]), 32'(i % 2));
        end

        // single requester never bubbles
        do_reset();
        req = 8'h01; gnt_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("single_b2_valid", 32'(d_valid[1]), 32'd1);
            check("single_b2_id", 32'(d_id[1]), 32'd0);
            check("single_b1_valid", 32'(d_valid[0]), 32'd1);
        end

        // wrap-around
        do_reset();
        req = 8'h81; mask = 8'h01;
        @(negedge clk);
        check("wrap_first_id", 32'(d_id[0]), 32'd7);
        mask = 8'h00; gnt_ready = 1'b1;
        @(negedge clk);
        check("wrap_b1_id", 32'(d_id[0]), 32'd0);
        check("wrap_b2_id", 32'(d_id[1]), 32'd7);
        check("wrap_mr", 32'(d_mr[0]), 32'h80);

        // flush in the same cycle as accept
        do_reset();
        req = 8'h08;
        @(negedge clk);
        check("flush_pre_id", 32'(d_id[0]), 32'd3);
        gnt_ready = 1'b1; flush = 1'b1;
        @(negedge clk);
        check("flush_valid", 32'(d_valid[0]), 32'd0);
        check("flush_gnt", 32'(d_gnt[1]), 32'h00);
        check("flush_mr", 32'(d_mr[0]), 32'h80);
        flush = 1'b0; gnt_ready = 1'b0;
        @(negedge clk);
        check("flush_regrant", 32'(d_id[0]), 32'd3);

        // reset mid-grant
        do_reset();
        req = 8'h40; gnt_ready = 1'b1;
        @(negedge clk);
        check("mrst_pre_id", 32'(d_id[0]), 32'd6);
        @(negedge clk);
        check("mrst_pre_mr", 32'(d_mr[0]), 32'h40);
        rst_n = 1'b0; req = 8'hFF;
        @(negedge clk);
        check("mrst_valid", 32'(d_valid[0]), 32'd0);
        check("mrst_gnt", 32'(d_gnt[0]), 32'h00);
        check("mrst_mr", 32'(d_mr[1]), 32'h80);
        rst_n = 1'b1;
        @(negedge clk);
        check("mrst_first_id", 32'(d_id[0]), 32'd0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst_n     = ($urandom_range(0, 299) != 0);
            req       = (i % 400 < 200) ? 8'($urandom) : 8'($urandom & $urandom);
            mask      = 8'($urandom & $urandom & $urandom);
            flush     = ($urandom_range(0, 24) == 0);
            gnt_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
